// File: rtl/operand_sender_pkg.sv
// Shared types and constants for the operand sender: FSM states, byte counts and
// parameter defaults.
package sender_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StSendSetup,
    StSendPulse,
    StSendGap,
    StWaitRdy,
    StResSetup,
    StResPulse,
    StResGap,
    StDone
  } state_e;

  localparam int unsigned BYTES_PER_OP    = 4;
  localparam int unsigned RESULT_BYTES    = 4;

  localparam int unsigned SETUP_CYC_DEF   = 1;
  localparam int unsigned PULSE_CYC_DEF   = 1;
  localparam int unsigned GAP_CYC_DEF     = 1;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/operand_sender_if.sv
// Handshake and byte bus between the operand sender and its user / peripherals unit.
interface operand_sender_if;
  logic        start;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  inputdata;
  logic        loaddata;
  logic        enter;
  logic        inputdata_ready;

  modport master (
    input  start, opA, opB, inputdata_ready,
    output busy, done, error, inputdata, loaddata, enter
  );

  modport slave (
    output start, opA, opB, inputdata_ready,
    input  busy, done, error, inputdata, loaddata, enter
  );
endinterface

// File: rtl/operand_sender_phase_timer.sv
// Loadable down-counter that saturates at zero; zero_o marks the last cycle of an interval.
module phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/operand_sender.sv
// Sends opA/opB as eight strobed bytes, waits for the peripherals unit, then strobes
// four result-display pulses.
module operand_sender
  import sender_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = SETUP_CYC_DEF,
  parameter int unsigned PULSE_CYC   = PULSE_CYC_DEF,
  parameter int unsigned GAP_CYC     = GAP_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              clk,
  input logic              reset,
  operand_sender_if.master bus
);

  localparam int unsigned MaxCyc = max4(SETUP_CYC, PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int unsigned TimerW = $clog2(MaxCyc + 1);
  localparam logic [2:0]  LastByte = 3'(2 * BYTES_PER_OP - 1);
  localparam logic [1:0]  LastRes  = 2'(RESULT_BYTES - 1);

  state_e      state_d, state_q;
  logic [63:0] sreg_d, sreg_q;
  logic [2:0]  byte_idx_d, byte_idx_q;
  logic [1:0]  res_idx_d, res_idx_q;
  logic        error_d, error_q;
  logic        busy_d, busy_q;
  logic        done_d, done_q;
  logic        enter_d, enter_q;
  logic        loaddata_d, loaddata_q;
  logic [7:0]  inputdata_d, inputdata_q;
  logic        send_d;

  logic              tmr_load, tmr_zero;
  logic [TimerW-1:0] tmr_val;

  phase_timer #(
    .Width (TimerW)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    byte_idx_d = byte_idx_q;
    res_idx_d  = res_idx_q;
    error_d    = error_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StSendSetup;
          sreg_d     = {bus.opA, bus.opB};
          byte_idx_d = '0;
          res_idx_d  = '0;
          error_d    = 1'b0;
        end
      end
      StSendSetup: if (tmr_zero) state_d = StSendPulse;
      StSendPulse: if (tmr_zero) state_d = StSendGap;
      StSendGap: begin
        if (tmr_zero) begin
          byte_idx_d = byte_idx_q + 3'd1;
          if (byte_idx_q == LastByte) begin
            state_d = StWaitRdy;
          end else begin
            state_d = StSendSetup;
            sreg_d  = {sreg_q[55:0], 8'h00};
          end
        end
      end
      StWaitRdy: begin
        // A ready seen on the final timeout cycle still wins over the timeout.
        if (bus.inputdata_ready) begin
          state_d = StResSetup;
        end else if (tmr_zero) begin
          state_d = StDone;
          error_d = 1'b1;
        end
      end
      StResSetup: if (tmr_zero) state_d = StResPulse;
      StResPulse: if (tmr_zero) state_d = StResGap;
      StResGap: begin
        if (tmr_zero) begin
          res_idx_d = res_idx_q + 2'd1;
          state_d   = (res_idx_q == LastRes) ? StDone : StResSetup;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Each interval is timed from the cycle its state is entered, so reload on every transition.
  always_comb begin
    tmr_load = (state_d != state_q);
    unique case (state_d)
      StSendSetup, StResSetup: tmr_val = TimerW'(SETUP_CYC - 1);
      StSendPulse, StResPulse: tmr_val = TimerW'(PULSE_CYC - 1);
      StSendGap, StResGap:     tmr_val = TimerW'(GAP_CYC - 1);
      StWaitRdy:               tmr_val = TimerW'(TIMEOUT_CYC - 1);
      default:                 tmr_val = '0;
    endcase
  end

  always_comb begin
    send_d      = (state_d inside {StSendSetup, StSendPulse, StSendGap});
    busy_d      = !(state_d inside {StIdle, StDone});
    done_d      = (state_d == StDone);
    enter_d     = (state_d inside {StSendPulse, StResPulse});
    loaddata_d  = send_d || (state_d == StWaitRdy);
    inputdata_d = send_d ? sreg_d[63:56] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      byte_idx_q  <= '0;
      res_idx_q   <= '0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      enter_q     <= 1'b0;
      loaddata_q  <= 1'b0;
      inputdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      byte_idx_q  <= byte_idx_d;
      res_idx_q   <= res_idx_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      enter_q     <= enter_d;
      loaddata_q  <= loaddata_d;
      inputdata_q <= inputdata_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.enter     = enter_q;
  assign bus.loaddata  = loaddata_q;
  assign bus.inputdata = inputdata_q;

endmodule

// File: tb/tb_operand_sender.sv
// Randomized bench for operand_sender: two instances (default and stretched timing) checked
// cycle by cycle against an arithmetic timeline model.
module tb_operand_sender;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       enter;
    logic       err;
    logic       ld;
    logic [7:0] id;
  } obs_t;

  typedef struct packed {
    bit         busy;
    bit         done;
    bit         enter;
    bit         err;
    bit         ld_v;
    bit         ld;
    bit         id_v;
    logic [7:0] id;
  } exp_t;

  int s_cyc [2] = '{1, 2};
  int p_cyc [2] = '{1, 3};
  int g_cyc [2] = '{1, 2};
  int t_cyc [2] = '{255, 20};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  bit          st  [2];
  bit          rdy [2];
  logic [31:0] opa [2];
  logic [31:0] opb [2];
  obs_t        obs [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operand_sender_if bus0 ();
  operand_sender_if bus1 ();

  assign bus0.start           = st[0];
  assign bus0.opA             = opa[0];
  assign bus0.opB             = opb[0];
  assign bus0.inputdata_ready = rdy[0];
  assign bus1.start           = st[1];
  assign bus1.opA             = opa[1];
  assign bus1.opB             = opb[1];
  assign bus1.inputdata_ready = rdy[1];
  assign obs[0] = {bus0.busy, bus0.done, bus0.enter, bus0.error, bus0.loaddata, bus0.inputdata};
  assign obs[1] = {bus1.busy, bus1.done, bus1.enter, bus1.error, bus1.loaddata, bus1.inputdata};

  operand_sender u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  operand_sender #(
    .SETUP_CYC   (2),
    .PULSE_CYC   (3),
    .GAP_CYC     (2),
    .TIMEOUT_CYC (20)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int done_rel(input int d, input int r0);
    int l;
    l = s_cyc[d] + p_cyc[d] + g_cyc[d];
    if (r0 >= t_cyc[d]) return 8 * l + 1 + t_cyc[d];
    return 8 * l + 1 + (r0 + 1) + 4 * l;
  endfunction

  // Expected outputs rel cycles after the start-sampling edge (rel=1 is the first busy cycle).
  function automatic exp_t model(input int d, input int rel, input logic [63:0] ops,
                                 input int r0);
    exp_t e;
    int   l, w, wr, rr, ph;
    bit   timed;
    l     = s_cyc[d] + p_cyc[d] + g_cyc[d];
    timed = (r0 >= t_cyc[d]);
    w     = timed ? t_cyc[d] : r0 + 1;
    e     = '0;
    if (rel <= 8 * l) begin
      ph      = (rel - 1) % l;
      e.busy  = 1'b1;
      e.enter = (ph >= s_cyc[d]) && (ph < s_cyc[d] + p_cyc[d]);
      e.ld_v  = 1'b1;
      e.ld    = 1'b1;
      e.id_v  = 1'b1;
      e.id    = ops[63 - 8 * ((rel - 1) / l) -: 8];
    end else begin
      wr = rel - 8 * l - 1;
      if (wr < w) begin
        e.busy = 1'b1;
      end else if (timed) begin
        e.err  = 1'b1;
        e.done = (wr == w);
      end else begin
        rr = wr - w;
        if (rr < 4 * l) begin
          ph      = rr % l;
          e.busy  = 1'b1;
          e.enter = (ph >= s_cyc[d]) && (ph < s_cyc[d] + p_cyc[d]);
          e.ld_v  = 1'b1;
          e.id_v  = 1'b1;
        end else begin
          e.done = (rr == 4 * l);
        end
      end
    end
    return e;
  endfunction

  // Starts one transfer on instance d and follows it until two cycles past done.
  // r0 = WAIT_RDY cycle on which ready rises (0: high throughout; >= timeout: never).
  task automatic run_txn(input string tag, input int d, input logic [31:0] a,
                         input logic [31:0] b, input int r0, input bit poke);
    int   k, dr, ready_at, l, pulses, seen_done;
    int   bad_busy, bad_done, bad_enter, bad_err, bad_ld, bad_id;
    logic prev_en;
    exp_t e;
    obs_t o;
    l        = s_cyc[d] + p_cyc[d] + g_cyc[d];
    dr       = done_rel(d, r0);
    k        = cyc;
    ready_at = (r0 == 0) ? 0 : k + 8 * l + 1 + r0;
    st[d]    = 1'b1;
    opa[d]   = a;
    opb[d]   = b;
    rdy[d]   = (k >= ready_at);
    prev_en  = 1'b0;
    pulses   = 0;
    seen_done = -1;
    bad_busy = 0; bad_done = 0; bad_enter = 0; bad_err = 0; bad_ld = 0; bad_id = 0;
    for (int c = k + 1; c <= k + dr + 2; c++) begin
      @(negedge clk);
      o = obs[d];
      e = model(d, c - k, {a, b}, r0);
      if (o.busy !== e.busy) bad_busy++;
      if (o.done !== e.done) bad_done++;
      if (o.enter !== e.enter) bad_enter++;
      if (o.err !== e.err) bad_err++;
      if (e.ld_v && (o.ld !== e.ld)) bad_ld++;
      if (e.id_v && (o.id !== e.id)) bad_id++;
      if (o.enter === 1'b1 && !prev_en) pulses++;
      prev_en = o.enter;
      if (o.done === 1'b1 && seen_done < 0) seen_done = c - k;
      st[d]  = poke && ((c - k < dr) ? ($urandom_range(0, 2) == 0) : (c - k == dr));
      opa[d] = $urandom;
      opb[d] = $urandom;
      rdy[d] = (c >= ready_at);
    end
    st[d] = 1'b0;
    check_eq({tag, ".busy_bad_cycles"}, bad_busy, 0);
    check_eq({tag, ".done_bad_cycles"}, bad_done, 0);
    check_eq({tag, ".enter_bad_cycles"}, bad_enter, 0);
    check_eq({tag, ".error_bad_cycles"}, bad_err, 0);
    check_eq({tag, ".loaddata_bad_cycles"}, bad_ld, 0);
    check_eq({tag, ".inputdata_bad_cycles"}, bad_id, 0);
    check_eq({tag, ".pulses"}, pulses, (r0 >= t_cyc[d]) ? 8 : 12);
    check_eq({tag, ".done_cycle"}, seen_done, dr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int d, r0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; rdy[i] = 1'b0; opa[i] = '0; opb[i] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_state0", obs[0], '0);
    check_eq("reset_state1", obs[1], '0);
    reset = 1'b0;
    @(negedge clk);

    check_eq("done_rel_default", done_rel(0, 0), 38);
    run_txn("basic", 0, 32'h40E00000, 32'hC0E01000, 0, 1'b0);
    run_txn("timeout", 0, $urandom, $urandom, 255, 1'b0);
    run_txn("after_timeout", 0, $urandom, $urandom, 0, 1'b0);
    run_txn("poke_busy", 0, $urandom, $urandom, 0, 1'b1);
    run_txn("slow_timing", 1, $urandom, $urandom, 0, 1'b0);
    run_txn("slow_poke", 1, $urandom, $urandom, 3, 1'b1);
    run_txn("late_ready", 0, $urandom, $urandom, 10, 1'b0);
    run_txn("slow_timeout", 1, $urandom, $urandom, 20, 1'b0);
    run_txn("ready_last", 1, $urandom, $urandom, 19, 1'b0);

    // Reset while the third load byte is being strobed.
    st[0] = 1'b1; opa[0] = $urandom; opb[0] = $urandom; rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      st[0] = 1'b0;
    end
    check_eq("mid_reset.enter_before", obs[0].enter, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_reset.outputs", obs[0], '0);
    reset = 1'b0;
    run_txn("resend", 0, 32'h3F800000, $urandom, 0, 1'b0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; st[0] = 1'b1;
    @(negedge clk);
    check_eq("rst_prio.busy", obs[0].busy, 1'b0);
    reset = 1'b0; st[0] = 1'b0;
    @(negedge clk);
    check_eq("rst_prio.busy_after", obs[0].busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      d  = $urandom_range(0, 1);
      r0 = ($urandom_range(0, 4) == 0) ? t_cyc[d] : $urandom_range(0, 12);
      run_txn($sformatf("rand%0d", i), d, $urandom, $urandom, r0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
